// File: rtl/colorspace_pkg.sv
// Shared colorspace definitions: subpixel width, RGB channel order and the
// serializer state encoding (each emitting state equals its channel index).
package colorspace_pkg;

  localparam int P_SUBPIXEL_DEPTH = 8;

  localparam logic [1:0] CH_R = 2'd0;
  localparam logic [1:0] CH_G = 2'd1;
  localparam logic [1:0] CH_B = 2'd2;

  typedef enum logic [1:0] {
    ST_RED   = CH_R,
    ST_GREEN = CH_G,
    ST_BLUE  = CH_B,
    ST_IDLE  = 2'd3
  } ser_state_e;

endpackage

// File: rtl/pixel_fifo.sv
// Synchronous FIFO with async active-high reset; pointers carry one extra
// wrap bit so full and empty are told apart by the MSB.
module pixel_fifo #(
  parameter int P_WIDTH = 8,
  parameter int P_DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic [P_WIDTH-1:0] data_i,
  input  logic               pop_i,
  output logic [P_WIDTH-1:0] data_o,
  output logic               full_o,
  output logic               empty_o
);

  localparam int AW = $clog2(P_DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW:0]        rd_ptr_q, rd_ptr_d;
  logic [P_WIDTH-1:0] mem_q [P_DEPTH];
  logic               push_ok_s, pop_ok_s;

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push_ok_s = push_i && !full_o;
  assign pop_ok_s  = pop_i && !empty_o;
  assign data_o    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_ok_s) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= {(AW+1){1'b0}};
      rd_ptr_q <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/gray_rgb_serializer.sv
// Buffers grayscale pixels and replays each one as a byte-serial R,G,B
// stream (luma replicated, optionally inverted) with valid/ready on both sides.
module gray_rgb_serializer #(
  parameter int P_SUBPIXEL_DEPTH = colorspace_pkg::P_SUBPIXEL_DEPTH,
  parameter int P_FIFO_DEPTH     = 4,
  parameter int P_COUNT_WIDTH    = 16
) (
  input  logic                        I_CLK,
  input  logic                        I_RESET,
  input  logic [P_SUBPIXEL_DEPTH-1:0] I_PIXEL,
  input  logic                        I_VALID,
  output logic                        O_READY,
  input  logic                        I_INVERT,
  output logic [P_SUBPIXEL_DEPTH-1:0] O_SUBPIXEL,
  output logic                        O_VALID,
  input  logic                        I_READY,
  output logic                        O_LAST,
  output logic [P_COUNT_WIDTH-1:0]    O_PIXEL_COUNT
);

  import colorspace_pkg::*;

  localparam logic [P_COUNT_WIDTH-1:0] CNT_ONE = {{(P_COUNT_WIDTH-1){1'b0}}, 1'b1};

  ser_state_e                  state_q, state_d;
  logic [P_SUBPIXEL_DEPTH-1:0] hold_q, hold_d;
  logic [P_SUBPIXEL_DEPTH-1:0] subpixel_q, subpixel_d;
  logic                        valid_q, valid_d;
  logic                        last_q, last_d;
  logic [P_COUNT_WIDTH-1:0]    count_q, count_d;
  logic [P_SUBPIXEL_DEPTH-1:0] fifo_data_s;
  logic                        fifo_full_s, fifo_empty_s;
  logic                        push_s, pop_s;

  assign O_READY       = !fifo_full_s && !I_RESET;
  assign push_s        = I_VALID && O_READY;
  assign O_SUBPIXEL    = subpixel_q;
  assign O_VALID       = valid_q;
  assign O_LAST        = last_q;
  assign O_PIXEL_COUNT = count_q;

  pixel_fifo #(
    .P_WIDTH (P_SUBPIXEL_DEPTH),
    .P_DEPTH (P_FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (I_CLK),
    .rst_i   (I_RESET),
    .push_i  (push_s),
    .data_i  (I_PIXEL),
    .pop_i   (pop_s),
    .data_o  (fifo_data_s),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s)
  );

  // Pops happen from IDLE or on the B handshake, so pixels chain with no bubble.
  always_comb begin
    state_d = state_q;
    pop_s   = 1'b0;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          pop_s   = 1'b1;
          state_d = ST_RED;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RED: begin
        if (I_READY) state_d = ST_GREEN;
        else         state_d = ST_RED;
      end
      ST_GREEN: begin
        if (I_READY) state_d = ST_BLUE;
        else         state_d = ST_GREEN;
      end
      ST_BLUE: begin
        if (I_READY) begin
          count_d = count_q + CNT_ONE;
          if (!fifo_empty_s) begin
            pop_s   = 1'b1;
            state_d = ST_RED;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_BLUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (pop_s) begin
      hold_d = I_INVERT ? ~fifo_data_s : fifo_data_s;
    end else begin
      hold_d = hold_q;
    end

    // Outputs are decoded from the next state so they register alongside it.
    valid_d = (state_d != ST_IDLE);
    last_d  = (state_d == ST_BLUE);
    if (state_d == ST_IDLE) begin
      subpixel_d = {P_SUBPIXEL_DEPTH{1'b0}};
    end else begin
      subpixel_d = hold_d;
    end
  end

  always_ff @(posedge I_CLK or posedge I_RESET) begin
    if (I_RESET) begin
      state_q    <= ST_IDLE;
      hold_q     <= {P_SUBPIXEL_DEPTH{1'b0}};
      subpixel_q <= {P_SUBPIXEL_DEPTH{1'b0}};
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      count_q    <= {P_COUNT_WIDTH{1'b0}};
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      subpixel_q <= subpixel_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      count_q    <= count_d;
    end
  end

endmodule

// File: doc/gray_rgb_serializer.md
Name: gray_rgb_serializer

Overview:
- Output-side counterpart to the RGB-to-grayscale stage.
- Accepts grayscale pixels over a valid/ready handshake and buffers them in a small FIFO.
- Expands each pixel back to RGB by replicating the luma value (optionally inverted) into R, G and B.
- Emits the result as a byte-serial R,G,B stream for the chip's pixel output interface (display/test-readback path).

Parameters:
P_SUBPIXEL_DEPTH, 8, width of one grayscale pixel and of each output subpixel
P_FIFO_DEPTH, 4, input FIFO entries; power of 2, >= 2
P_COUNT_WIDTH, 16, width of the emitted-pixel counter

Ports:
I_CLK  input  1  clock
I_RESET  input  1  reset; asynchronous, active-high
I_PIXEL  input  P_SUBPIXEL_DEPTH  grayscale pixel in
I_VALID  input  1  I_PIXEL is valid
O_READY  output  1  block can accept a pixel this cycle
I_INVERT  input  1  invert luma of the pixel being popped from the FIFO
O_SUBPIXEL  output  P_SUBPIXEL_DEPTH  serial subpixel out (R, then G, then B)
O_VALID  output  1  O_SUBPIXEL is valid
I_READY  input  1  downstream accepts O_SUBPIXEL
O_LAST  output  1  high with the B subpixel (end of pixel)
O_PIXEL_COUNT  output  P_COUNT_WIDTH  count of fully emitted pixels, wraps

Behaviour:
- Clock and reset: one clock, I_CLK. Reset I_RESET is asynchronous and active-high; it clears all state immediately, without a clock edge.
- Reset values:
  - O_VALID=0, O_LAST=0, O_SUBPIXEL=0, O_PIXEL_COUNT=0.
  - FIFO empty; FSM in IDLE.
  - O_READY=0 while I_RESET is high.
- Input side:
  - O_READY = !fifo_full (combinational).
  - Push on a rising edge when I_VALID && O_READY.
  - No push when full, even if a pop happens in the same cycle.
  - I_PIXEL is ignored when I_VALID=0.
- Hold register: the popped pixel is stored as hold = I_INVERT ? ~data : data, with I_INVERT sampled at the pop edge.
- FSM states: IDLE, RED, GREEN, BLUE.
  - IDLE: if FIFO non-empty, pop into hold and go to RED; otherwise stay in IDLE.
  - RED: O_VALID=1, O_SUBPIXEL=hold. On I_READY, go to GREEN; otherwise hold.
  - GREEN: same as RED; on I_READY, go to BLUE.
  - BLUE: O_VALID=1, O_LAST=1.
    - On I_READY: O_PIXEL_COUNT+1.
    - If FIFO non-empty: pop the next pixel and go to RED (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Output registers: O_SUBPIXEL, O_VALID and O_LAST are registered, decoded from the next state.
- Output stability: outputs are stable while O_VALID && !I_READY (AXI-style). O_VALID never drops without a handshake.
- Latency: pixel pushed at edge N gives R visible after edge N+1 with an empty FIFO and IDLE FSM.
- Throughput: 1 pixel per 3 accepted output cycles. With I_READY tied high the output is gapless.
- Simultaneous push and pop on a non-full FIFO: both happen; occupancy is unchanged.
- Pointer wrap-around: FIFO pointers are log2(P_FIFO_DEPTH)+1 bits. Full and empty are distinguished by the MSB.
- Counter: O_PIXEL_COUNT wraps from all-ones to 0 with no flag.
- Reset mid-pixel: the partial pixel is dropped, the FIFO is flushed, and no O_LAST is emitted.

Decomposition:
- Shared package (colorspace_pkg): P_SUBPIXEL_DEPTH default, RGB channel-order constants (R=0, G=1, B=2) and the FSM state encodings, also used by grayscale.
- One sub-module, pixel_fifo: a parameterised synchronous FIFO with async reset, push/pop, full/empty.
  - The FSM, hold register, inversion and counter stay in gray_rgb_serializer.

Test Plan:
1. Reset, then push 0x5A with I_READY=1, I_INVERT=0 -> 0x5A,0x5A,0x5A on three consecutive cycles starting 2 cycles after push; O_LAST only on the third; O_PIXEL_COUNT=1.
2. Push 0x0F with I_INVERT=1 at the pop edge -> 0xF0 emitted three times; I_INVERT toggled during emission has no effect.
3. Burst of 6 pixels (0x01..0x06) back-to-back with I_READY=0 -> O_READY drops after 4 accepted plus 1 in hold; O_SUBPIXEL stays 0x01 while stalled; releasing I_READY gives 18 gapless bytes in order; count=6.
4. Random I_READY (50%) over 100 random pixels -> scoreboard matches every byte; outputs stable during stalls; O_LAST every 3rd handshake.
5. Assert I_RESET asynchronously (between edges) during GREEN -> O_VALID=0 and O_PIXEL_COUNT=0 immediately; after release, the first pixel pushed is the first emitted.
6. Preload O_PIXEL_COUNT to 0xFFFE via 2 pixels after forcing -> count goes 0xFFFF then 0x0000.
